datapath_ctrl: RTL and testbench

Finite-state controller that sequences the Simple RISC Machine datapath (register file, A/B/C pipeline registers, shifter, ALU, status register) for one instruction at a time. It takes a start pulse plus decoded opcode/op fields and issues the per-cycle load, select and write strobes that move operands through the ALU and write results back. It sits between the instruction register/decoder and the datapath, and tells the top level when it is idle via `w`.

---
 rtl/datapath_ctrl_pkg.sv | 47 ++++
 rtl/datapath_ctrl_if.sv | 30 +++
 rtl/datapath_ctrl_ins_class_dec.sv | 25 ++
 rtl/datapath_ctrl.sv | 125 ++++++++++++
 tb/tb_datapath_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the Simple RISC Machine datapath controller.
package ctrl_pkg;

  localparam int unsigned OPC_W   = 3;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_GET_A  = 3'd2,
    ST_GET_B  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WR_REG = 3'd5,
    ST_WR_IMM = 3'd6
  } state_t;

  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] ALU_ADD  = 2'b00;
  localparam logic [OP_W-1:0] ALU_SUB  = 2'b01;
  localparam logic [OP_W-1:0] ALU_AND  = 2'b10;
  localparam logic [OP_W-1:0] ALU_NOTB = 2'b11;

  localparam logic [SEL_W-1:0] NSEL_RN = 3'b001;
  localparam logic [SEL_W-1:0] NSEL_RD = 3'b010;
  localparam logic [SEL_W-1:0] NSEL_RM = 3'b100;

  // Registered controller output bundle.
  typedef struct packed {
    logic             w;
    logic [SEL_W-1:0] nsel;
    logic             loada;
    logic             loadb;
    logic             loadc;
    logic             loads;
    logic             asel;
    logic             bsel;
    logic             vsel;
    logic             write;
    logic [OP_W-1:0]  alu_op;
    logic             illegal;
  } ctrl_out_t;

endpackage

// File: rtl/datapath_ctrl_if.sv
// Decoder-to-controller handshake plus controller-to-datapath strobes.
interface datapath_ctrl_if #(
  parameter int unsigned NSEL_W = 3
);
  logic              s;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic              w;
  logic [NSEL_W-1:0] nsel;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic              vsel;
  logic              write;
  logic [1:0]        alu_op;
  logic              illegal;

  modport master (
    output s, opcode, op,
    input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, alu_op, illegal
  );

  modport slave (
    input  s, opcode, op,
    output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, alu_op, illegal
  );
endinterface

// File: rtl/datapath_ctrl_ins_class_dec.sv
// Maps {opcode, op} onto the instruction classes the controller sequences.
module ins_class_dec
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [OP_W-1:0]  i_op,
  output logic             o_is_mov_imm,
  output logic             o_is_mov_reg,
  output logic             o_is_alu2,
  output logic             o_is_cmp,
  output logic             o_is_mvn,
  output logic             o_is_illegal
);
  logic w_mov;
  logic w_alu;

  assign w_mov        = (i_opcode == OPC_MOV);
  assign w_alu        = (i_opcode == OPC_ALU);
  assign o_is_mov_imm = w_mov && (i_op == 2'b10);
  assign o_is_mov_reg = w_mov && (i_op == 2'b00);
  assign o_is_alu2    = w_alu && ((i_op == ALU_ADD) || (i_op == ALU_AND));
  assign o_is_cmp     = w_alu && (i_op == ALU_SUB);
  assign o_is_mvn     = w_alu && (i_op == ALU_NOTB);
  assign o_is_illegal = !(o_is_mov_imm || o_is_mov_reg || o_is_alu2 || o_is_cmp || o_is_mvn);
endmodule

// File: rtl/datapath_ctrl.sv
// One-instruction-at-a-time sequencer for the SRM datapath. Outputs are
// registered from the next state so they always reflect the current state.
module datapath_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned NSEL_W = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  datapath_ctrl_if.slave  bus
);
  state_t           r_state;
  logic [OPC_W-1:0] r_opc;
  logic [OP_W-1:0]  r_op;
  ctrl_out_t        r_out;

  state_t           w_nxt_state;
  logic [OPC_W-1:0] w_nxt_opc;
  logic [OP_W-1:0]  w_nxt_op;
  ctrl_out_t        w_nxt_out;
  logic             w_mov_imm, w_mov_reg, w_alu2, w_cmp, w_mvn, w_illegal;

  // Fields only change in WAIT, so classifying the next fields also serves DECODE/EXEC.
  ins_class_dec u_dec (
    .i_opcode     (w_nxt_opc),
    .i_op         (w_nxt_op),
    .o_is_mov_imm (w_mov_imm),
    .o_is_mov_reg (w_mov_reg),
    .o_is_alu2    (w_alu2),
    .o_is_cmp     (w_cmp),
    .o_is_mvn     (w_mvn),
    .o_is_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_WAIT;
      r_opc   <= '0;
      r_op    <= '0;
      r_out   <= '0;
      r_out.w <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      r_opc   <= w_nxt_opc;
      r_op    <= w_nxt_op;
      r_out   <= w_nxt_out;
    end
  end

  // Next state and latched fields.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_opc   = r_opc;
    w_nxt_op    = r_op;
    case (r_state)
      ST_WAIT: begin
        if (bus.s) begin
          w_nxt_state = ST_DECODE;
          w_nxt_opc   = bus.opcode;
          w_nxt_op    = bus.op;
        end
      end
      ST_DECODE: begin
        if (w_mov_imm)                 w_nxt_state = ST_WR_IMM;
        else if (w_mov_reg || w_mvn)   w_nxt_state = ST_GET_B;
        else if (w_alu2 || w_cmp)      w_nxt_state = ST_GET_A;
        else                           w_nxt_state = ST_WAIT;
      end
      ST_GET_A:  w_nxt_state = ST_GET_B;
      ST_GET_B:  w_nxt_state = ST_EXEC;
      ST_EXEC:   w_nxt_state = w_cmp ? ST_WAIT : ST_WR_REG;
      ST_WR_REG: w_nxt_state = ST_WAIT;
      ST_WR_IMM: w_nxt_state = ST_WAIT;
      default:   w_nxt_state = ST_WAIT;
    endcase
  end

  // Moore output decode of the state about to be entered.
  always_comb begin
    w_nxt_out = '0;
    if (w_nxt_state != ST_WAIT) begin
      w_nxt_out.alu_op = (w_nxt_opc == OPC_ALU) ? w_nxt_op : ALU_ADD;
    end
    case (w_nxt_state)
      ST_WAIT:   w_nxt_out.w = 1'b1;
      ST_DECODE: w_nxt_out.illegal = w_illegal;
      ST_GET_A: begin
        w_nxt_out.nsel  = NSEL_RN;
        w_nxt_out.loada = 1'b1;
      end
      ST_GET_B: begin
        w_nxt_out.nsel  = NSEL_RM;
        w_nxt_out.loadb = 1'b1;
      end
      ST_EXEC: begin
        w_nxt_out.asel  = w_mov_reg || w_mvn;
        w_nxt_out.loads = w_cmp;
        w_nxt_out.loadc = !w_cmp;
      end
      ST_WR_REG: begin
        w_nxt_out.nsel  = NSEL_RD;
        w_nxt_out.write = 1'b1;
      end
      ST_WR_IMM: begin
        w_nxt_out.nsel  = NSEL_RN;
        w_nxt_out.vsel  = 1'b1;
        w_nxt_out.write = 1'b1;
      end
      default: w_nxt_out.w = 1'b1;
    endcase
  end

  assign bus.w       = r_out.w;
  assign bus.nsel    = NSEL_W'(r_out.nsel);
  assign bus.loada   = r_out.loada;
  assign bus.loadb   = r_out.loadb;
  assign bus.loadc   = r_out.loadc;
  assign bus.loads   = r_out.loads;
  assign bus.asel    = r_out.asel;
  assign bus.bsel    = r_out.bsel;
  assign bus.vsel    = r_out.vsel;
  assign bus.write   = r_out.write;
  assign bus.alu_op  = r_out.alu_op;
  assign bus.illegal = r_out.illegal;
endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed scoreboard bench for datapath_ctrl: expected per-cycle strobe
// vectors are queued when an instruction is issued and popped each cycle.
module tb_datapath_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  logic [14:0] sb_q[$];

  datapath_ctrl_if #(.NSEL_W(3)) bus ();

  datapath_ctrl #(.NSEL_W(3)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Packing: {w, nsel[2:0], loada, loadb, loadc, loads, asel, bsel, vsel, write, alu_op[1:0], illegal}
  function automatic logic [14:0] mk(input logic w, input logic [2:0] nsel,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic asel, input logic vsel,
                                     input logic wr, input logic [1:0] aop, input logic ill);
    return {w, nsel, la, lb, lc, ls, asel, 1'b0, vsel, wr, aop, ill};
  endfunction

  function automatic logic [14:0] obs();
    return {bus.w, bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel,
            bus.bsel, bus.vsel, bus.write, bus.alu_op, bus.illegal};
  endfunction

  function automatic logic [14:0] idle_v();
    return mk(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [14:0] o, input logic [14:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s obs=%b exp=%b", tag, o, e);
    end
  endtask

  // Reference sequence: one entry per busy cycle plus the WAIT cycle that follows.
  task automatic push_seq(input logic [2:0] opc, input logic [1:0] op);
    logic [1:0] a;
    a = (opc == 3'b101) ? op : 2'b00;
    if (opc == 3'b110 && op == 2'b10) begin
      sb_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b001, 0, 0, 0, 0, 0, 1, 1, a, 0));
    end else if (opc == 3'b110 && op == 2'b00) begin
      sb_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b000, 0, 0, 1, 0, 1, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 0, 1, a, 0));
    end else if (opc == 3'b101 && op == 2'b11) begin
      sb_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b000, 0, 0, 1, 0, 1, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 0, 1, a, 0));
    end else if (opc == 3'b101 && op == 2'b01) begin
      sb_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b001, 1, 0, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 0, a, 0));
    end else if (opc == 3'b101) begin
      sb_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b001, 1, 0, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b000, 0, 0, 1, 0, 0, 0, 0, a, 0));
      sb_q.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 0, 1, a, 0));
    end else begin
      sb_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    end
    sb_q.push_back(idle_v());
  endtask

  // Issue one instruction from a negedge in WAIT; optionally keep s high and
  // scribble on opcode/op after busy cycle flip_at (0 = never).
  task automatic run(input string name, input logic [2:0] opc, input logic [1:0] op,
                     input bit keep_s, input int flip_at);
    int cyc;
    bus.s      = 1'b1;
    bus.opcode = opc;
    bus.op     = op;
    push_seq(opc, op);
    cyc = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      if (!keep_s) bus.s = 1'b0;
      check($sformatf("%s_c%0d", name, cyc), obs(), sb_q.pop_front());
      if (cyc == flip_at) begin
        bus.opcode = 3'b110;
        bus.op     = 2'b10;
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    bus.s      = 1'b0;
    bus.opcode = 3'b000;
    bus.op     = 2'b00;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_%0d", i), obs(), idle_v());
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", obs(), idle_v());

    run("mov_imm", 3'b110, 2'b10, 1'b0, 0);
    run("add",     3'b101, 2'b00, 1'b0, 0);
    run("cmp",     3'b101, 2'b01, 1'b0, 0);
    run("mvn",     3'b101, 2'b11, 1'b0, 0);
    run("and",     3'b101, 2'b10, 1'b0, 0);
    run("mov_reg", 3'b110, 2'b00, 1'b0, 0);
    run("ill_111", 3'b111, 2'b00, 1'b0, 0);
    run("ill_110", 3'b110, 2'b01, 1'b0, 0);

    // s held high: MOV reg then ADD, with the ADD fields overwritten mid-flight.
    run("b2b_mov", 3'b110, 2'b00, 1'b1, 0);
    run("b2b_add", 3'b101, 2'b00, 1'b0, 2);
    @(negedge clk);
    check("b2b_tail_idle", obs(), idle_v());

    // Abort an ADD in EXEC; nothing must reach write.
    bus.s      = 1'b1;
    bus.opcode = 3'b101;
    bus.op     = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.s = 1'b0;
    end
    check("abort_exec", obs(), mk(0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
    #2 reset_n = 1'b0;
    #1 check("abort_async", obs(), idle_v());
    @(negedge clk);
    check("abort_held", obs(), idle_v());
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_released", obs(), idle_v());

    run("recover_cmp", 3'b101, 2'b01, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
